regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32x32 integer register file. It shares the file's single write port (we3/ar3i/r3i) among NREQ write-back requesters (ALU, LSU, MUL/DIV) using round-robin valid/ready arbitration. It also tracks per-register busy bits for in-flight destinations and raises a hazard to hold decode/issue. It sits between the execute/memory units and the register file, next to the decode stage.

---
 rtl/regfile_wb_arbiter_pkg.sv | 27 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants for the register-file write-back arbiter and scoreboard.
//   NUM_REGS : number of integer registers tracked by the scoreboard
//   AW       : register address width
//   XLEN     : register data width
//   REQ_*    : fixed requester slots on the write-back arbiter
// reg_mask() turns a register address into a one-hot scoreboard mask.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int XLEN     = 32;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_MDU  = 2;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [AW-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin valid/ready arbiter. The requester at the pointer has top
// priority, then pointer+1, and so on, wrapping modulo NREQ. The grant is
// combinational; the pointer moves to the slot after the winner on accept.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset (also forces grant to zero)
//   i_valid  : per-requester valid
//   o_grant  : one-hot (or zero) grant, doubles as ready
//   o_accept : a grant was issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant,
    output logic            o_accept
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_idx;
    logic            w_found;
    logic [NREQ-1:0] w_grant;

    // Scan distances 0..NREQ-1 from the pointer; the first valid requester
    // met in that order wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && i_valid[i] && ((int'(r_ptr) + k) % NREQ == i)) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_idx      = PW'(i);
                end
            end
        end
    end

    // Nobody may see ready while the block is held in reset.
    assign o_grant  = i_rst_n ? w_grant : '0;
    assign o_accept = |o_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (o_accept) begin
            r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port among NREQ write-back
// requesters and keeps a busy scoreboard of in-flight destinations so decode
// can stall on RAW/WAW hazards.
//   clk, rst             : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester write-back handshake
//   req_addr/req_data    : packed destination/data, requester i at [i*W +: W]
//   issue_valid          : decode wants to issue
//   issue_rd/rs1/rs2     : destination and sources of that instruction
//   hazard               : issue must stall this cycle
//   we3/ar3i/r3i         : registered register-file write port
//   busy                 : scoreboard, bit r set = x<r> has a pending producer
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::NUM_REGS;
    import regfile_wb_arbiter_pkg::reg_mask;
#(
    parameter int NREQ = 3,
    parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
    parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        issue_rs1,
    input  logic [AW-1:0]        issue_rs2,
    output logic                 hazard,
    output logic                 we3,
    output logic [AW-1:0]        ar3i,
    output logic [XLEN-1:0]      r3i,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NREQ-1:0]     w_grant;
    logic                w_accept;
    logic [AW-1:0]       w_sel_addr;
    logic [XLEN-1:0]     w_sel_data;

    logic                r_we3;
    logic [AW-1:0]       r_ar3i;
    logic [XLEN-1:0]     r_r3i;
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_avail_busy;
    logic                w_hazard;
    logic                w_fire;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr_arbiter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_valid (req_valid),
        .o_grant (w_grant),
        .o_accept(w_accept)
    );

    assign req_ready = w_grant;

    // Route the winning requester's address/data to the output stage.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Write port stage. A write-back to x0 is accepted but never enables the
    // file; address/data hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we3  <= 1'b0;
            r_ar3i <= '0;
            r_r3i  <= '0;
        end else if (w_accept) begin
            r_we3  <= (w_sel_addr != '0);
            r_ar3i <= w_sel_addr;
            r_r3i  <= w_sel_data;
        end else begin
            r_we3  <= 1'b0;
        end
    end

    // The register being written this cycle commits on the falling edge, so
    // it no longer blocks a dependent issue even though its busy bit only
    // drops at the next rising edge.
    assign w_clr_mask   = r_we3 ? reg_mask(r_ar3i) : '0;
    assign w_avail_busy = r_busy & ~w_clr_mask;

    assign w_hazard = issue_valid &&
                      ((issue_rs1 != '0 && w_avail_busy[issue_rs1]) ||
                       (issue_rs2 != '0 && w_avail_busy[issue_rs2]) ||
                       (issue_rd  != '0 && w_avail_busy[issue_rd]));
    assign w_fire     = issue_valid && !w_hazard;
    assign w_set_mask = (w_fire && issue_rd != '0) ? reg_mask(issue_rd) : '0;

    // Set is applied after clear so a new producer wins over a retiring one.
    // Bit 0 is never set because the set mask excludes x0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign hazard = w_hazard;
    assign we3    = r_we3;
    assign ar3i   = r_ar3i;
    assign r3i    = r_r3i;
    assign busy   = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter (NREQ=3). Inputs change on the
// falling edge, outputs are sampled away from the rising edge, and a
// behavioural model of the arbiter/scoreboard rules supplies expectations.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [14:0]   req_addr;
    logic [95:0]   req_data;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    issue_rs1;
    logic [4:0]    issue_rs2;
    logic          hazard;
    logic          we3;
    logic [4:0]    ar3i;
    logic [31:0]   r3i;
    logic [31:0]   busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mPtr;
    logic [31:0] mBusy;
    logic        mWe3;
    logic [4:0]  mAr3i;
    logic [31:0] mR3i;

    regfile_wb_arbiter #(
        .NREQ(NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_rs1  (issue_rs1),
        .issue_rs2  (issue_rs2),
        .hazard     (hazard),
        .we3        (we3),
        .ar3i       (ar3i),
        .r3i        (r3i),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mPtr  = 0;
        mBusy = '0;
        mWe3  = 1'b0;
        mAr3i = '0;
        mR3i  = '0;
    endtask

    // First valid requester scanning from the pointer, wrapping around.
    function automatic logic [NR-1:0] modelReady();
        logic [NR-1:0] g;
        int idx;
        g = '0;
        if (rst !== 1'b1) return g;
        for (int k = 0; k < NR; k++) begin
            idx = (mPtr + k) % NR;
            if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // A register committing this cycle is treated as already available.
    function automatic logic modelHazard();
        logic [31:0] pending;
        pending = mBusy;
        if (mWe3) pending[mAr3i] = 1'b0;
        if (!issue_valid) return 1'b0;
        return (issue_rs1 != 0 && pending[issue_rs1]) ||
               (issue_rs2 != 0 && pending[issue_rs2]) ||
               (issue_rd  != 0 && pending[issue_rd]);
    endfunction

    task automatic modelEdge();
        logic [NR-1:0] g;
        logic          hz;
        logic [31:0]   nb;
        if (rst !== 1'b1) begin
            modelReset();
            return;
        end
        g  = modelReady();
        hz = modelHazard();
        nb = mBusy;
        if (mWe3) nb[mAr3i] = 1'b0;
        if (issue_valid && !hz && issue_rd != 0) nb[issue_rd] = 1'b1;
        mWe3 = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                mAr3i = req_addr[i*5 +: 5];
                mR3i  = req_data[i*32 +: 32];
                mWe3  = (mAr3i != 0);
                mPtr  = (i + 1) % NR;
            end
        end
        mBusy = nb;
    endtask

    // Drive one cycle of inputs and settle combinational outputs.
    task automatic applyStimulus(input logic [NR-1:0] v, input logic [14:0] a,
                                 input logic [95:0] d, input logic iv,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        issue_valid = iv;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        #1;
    endtask

    // Advance the model and the DUT across one rising edge; ends on a falling edge.
    task automatic clockEdge();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        applyStimulus('0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        clockEdge();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        modelReset();
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b1, 5'd5, 5'd5, 5'd0);
        total++; if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL reset_ready got=%b want=000", req_ready); end
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL reset_hazard got=%b want=0", hazard); end
        total++; if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_we3 got=%b want=0", we3); end
        total++; if (busy !== 32'h0) begin bad++; $display("[TB] FAIL reset_busy got=%h want=0", busy); end
        total++; if (ar3i !== 5'd0 || r3i !== 32'h0) begin bad++; $display("[TB] FAIL reset_port got=%h/%h want=0/0", ar3i, r3i); end
        clockEdge();
        total++; if (busy !== 32'h0 || we3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold got=%h/%b want=0/0", busy, we3); end
        rst = 1'b1;
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 5'd0, 5'd0, 5'd0);
        total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL reset_first_grant got=%b want=001", req_ready); end
        clockEdge();
        total++; if (we3 !== 1'b1 || ar3i !== 5'd1 || r3i !== 32'h11) begin bad++; $display("[TB] FAIL reset_first_wb got=%b/%h/%h want=1/01/11", we3, ar3i, r3i); end
    endtask

    task automatic test_round_robin();
        int cnt [NR];
        logic [NR-1:0] expG;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        resetDut();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, {5'd3, 5'd2, 5'd1},
                          {32'(300 + c), 32'(200 + c), 32'(100 + c)}, 1'b0, 5'd0, 5'd0, 5'd0);
            expG = 3'b001 << (c % 3);
            total++; if (req_ready !== expG) begin bad++; $display("[TB] FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, expG); end
            for (int i = 0; i < NR; i++) if (req_ready[i]) cnt[i]++;
            clockEdge();
            total++; if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL rr_we3 c=%0d got=%b want=1", c, we3); end
            total++; if (ar3i !== 5'(c % 3 + 1)) begin bad++; $display("[TB] FAIL rr_ar3i c=%0d got=%0d want=%0d", c, ar3i, c % 3 + 1); end
            total++; if (r3i !== 32'(100 * (c % 3 + 1) + c)) begin bad++; $display("[TB] FAIL rr_r3i c=%0d got=%0d want=%0d", c, r3i, 100 * (c % 3 + 1) + c); end
        end
        for (int i = 0; i < NR; i++) begin
            total++; if (cnt[i] != 2) begin bad++; $display("[TB] FAIL rr_fair req=%0d got=%0d want=2", i, cnt[i]); end
        end
    endtask

    task automatic test_raw_stall();
        logic [NR-1:0] lsuBit;
        lsuBit = '0;
        lsuBit[REQ_LSU] = 1'b1;
        resetDut();
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd5, 5'd0, 5'd0);
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL raw_issue_rd got=%b want=0", hazard); end
        clockEdge();
        total++; if (busy[5] !== 1'b1) begin bad++; $display("[TB] FAIL raw_busy_set got=%b want=1", busy[5]); end
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd0, 5'd5, 5'd0);
        total++; if (hazard !== 1'b1) begin bad++; $display("[TB] FAIL raw_stall got=%b want=1", hazard); end
        clockEdge();
        applyStimulus(lsuBit, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b1, 5'd0, 5'd5, 5'd0);
        total++; if (hazard !== 1'b1) begin bad++; $display("[TB] FAIL raw_stall_wb got=%b want=1", hazard); end
        total++; if (req_ready !== lsuBit) begin bad++; $display("[TB] FAIL raw_lsu_ready got=%b want=%b", req_ready, lsuBit); end
        clockEdge();
        total++; if (we3 !== 1'b1 || ar3i !== 5'd5 || r3i !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL raw_wb got=%b/%h/%h want=1/05/deadbeef", we3, ar3i, r3i); end
        total++; if (busy[5] !== 1'b1) begin bad++; $display("[TB] FAIL raw_busy_hold got=%b want=1", busy[5]); end
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd0, 5'd5, 5'd0);
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL raw_release got=%b want=0", hazard); end
        clockEdge();
        total++; if (busy !== 32'h0 || we3 !== 1'b0) begin bad++; $display("[TB] FAIL raw_clear got=%h/%b want=0/0", busy, we3); end
    endtask

    task automatic test_x0();
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL x0_hazard got=%b want=0", hazard); end
        clockEdge();
        total++; if (busy !== 32'h0) begin bad++; $display("[TB] FAIL x0_busy got=%h want=0", busy); end
        applyStimulus(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 1'b0, 5'd0, 5'd0, 5'd0);
        total++; if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL x0_ready got=%b want=010", req_ready); end
        clockEdge();
        total++; if (we3 !== 1'b0 || ar3i !== 5'd0 || r3i !== 32'h1234) begin bad++; $display("[TB] FAIL x0_drop got=%b/%h/%h want=0/00/1234", we3, ar3i, r3i); end
    endtask

    task automatic test_collision();
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        clockEdge();
        total++; if (busy !== 32'h80) begin bad++; $display("[TB] FAIL col_setup got=%h want=80", busy); end
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77}, 1'b0, 5'd0, 5'd0, 5'd0);
        total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL col_ready got=%b want=001", req_ready); end
        clockEdge();
        total++; if (we3 !== 1'b1 || ar3i !== 5'd7) begin bad++; $display("[TB] FAIL col_wb got=%b/%h want=1/07", we3, ar3i); end
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd7, 5'd0, 5'd0);
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL col_hazard got=%b want=0", hazard); end
        clockEdge();
        total++; if (busy !== 32'h80 || we3 !== 1'b0) begin bad++; $display("[TB] FAIL col_set_wins got=%h/%b want=80/0", busy, we3); end
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd0, 5'd7, 5'd0);
        total++; if (hazard !== 1'b1) begin bad++; $display("[TB] FAIL col_still_busy got=%b want=1", hazard); end
        clockEdge();
    endtask

    task automatic test_random();
        logic [NR-1:0] expG;
        logic          expH;
        resetDut();
        for (int c = 0; c < 300; c++) begin
            applyStimulus(NR'($urandom_range(0, 7)),
                          {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))},
                          {$urandom, $urandom, $urandom},
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            expG = modelReady();
            expH = modelHazard();
            total++; if (req_ready !== expG) begin bad++; $display("[TB] FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, expG); end
            total++; if (hazard !== expH) begin bad++; $display("[TB] FAIL rnd_hazard c=%0d got=%b want=%b", c, hazard, expH); end
            clockEdge();
            total++; if (we3 !== mWe3 || ar3i !== mAr3i || r3i !== mR3i) begin bad++; $display("[TB] FAIL rnd_port c=%0d got=%b/%h/%h want=%b/%h/%h", c, we3, ar3i, r3i, mWe3, mAr3i, mR3i); end
            total++; if (busy !== mBusy) begin bad++; $display("[TB] FAIL rnd_busy c=%0d got=%h want=%h", c, busy, mBusy); end
        end
    endtask

    task automatic test_mid_reset();
        resetDut();
        for (int r = 4; r < 7; r++) begin
            applyStimulus(3'b000, '0, '0, 1'b1, 5'(r), 5'd0, 5'd0);
            clockEdge();
        end
        applyStimulus(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b1, 5'd7, 5'd0, 5'd0);
        clockEdge();
        total++; if (busy !== 32'hF0 || we3 !== 1'b1 || ar3i !== 5'd9) begin bad++; $display("[TB] FAIL mid_setup got=%h/%b/%h want=f0/1/09", busy, we3, ar3i); end
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        total++; if (we3 !== 1'b0 || busy !== 32'h0) begin bad++; $display("[TB] FAIL mid_reset got=%b/%h want=0/0", we3, busy); end
        total++; if (ar3i !== 5'd0 || r3i !== 32'h0 || req_ready !== 3'b000) begin bad++; $display("[TB] FAIL mid_reset_port got=%h/%h/%b want=0/0/000", ar3i, r3i, req_ready); end
        clockEdge();
        rst = 1'b1;
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, 5'd0, 5'd0);
        total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL mid_restart got=%b want=001", req_ready); end
        clockEdge();
        total++; if (we3 !== 1'b1 || ar3i !== 5'd1) begin bad++; $display("[TB] FAIL mid_restart_wb got=%b/%h want=1/01", we3, ar3i); end
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        modelReset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_raw_stall();
        test_x0();
        test_collision();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
